// File: rtl/simplez_pkg.sv
// Shared constants, opcode values and FSM state encoding for the Simplez CPU.
package simplez_pkg;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ST   = 3'd0;
    localparam logic [OP_W-1:0] OP_LD   = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD  = 3'd2;
    localparam logic [OP_W-1:0] OP_BR   = 3'd3;
    localparam logic [OP_W-1:0] OP_BZ   = 3'd4;
    localparam logic [OP_W-1:0] OP_CLR  = 3'd5;
    localparam logic [OP_W-1:0] OP_DEC  = 3'd6;
    localparam logic [OP_W-1:0] OP_HALT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    function automatic logic [OP_W-1:0] ir_op(input logic [DATA_W-1:0] ir);
        return ir[DATA_W-1 -: OP_W];
    endfunction

    function automatic logic [ADDR_W-1:0] ir_cd(input logic [DATA_W-1:0] ir);
        return ir[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/simplez_alu.sv
// Combinational accumulator update for the EXEC cycle, plus the ACC==0 flag used by BZ.
module simplez_alu
    import simplez_pkg::*;
(
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_mem_din,
    output logic [DATA_W-1:0] o_acc_nxt_c,
    output logic              o_zero_c
);

    // Opcodes that do not touch ACC pass it through unchanged.
    always_comb begin
        o_acc_nxt_c = i_acc;
        case (i_op)
            OP_LD:   o_acc_nxt_c = i_mem_din;
            OP_ADD:  o_acc_nxt_c = i_acc + i_mem_din;
            OP_CLR:  o_acc_nxt_c = '0;
            OP_DEC:  o_acc_nxt_c = i_acc - DATA_W'(1);
            default: o_acc_nxt_c = i_acc;
        endcase
    end

    assign o_zero_c = (i_acc == '0);

endmodule

// File: rtl/simplez_cpu.sv
// Simplez 12-bit accumulator CPU: two-cycle FETCH/EXEC control unit, PC, IR and ACC.
module simplez_cpu
    import simplez_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(0)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [DATA_W-1:0] mem_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_dout,
    output logic              halt,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc
);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [DATA_W-1:0] r_acc, w_acc_nxt;
    logic [DATA_W-1:0] r_ir, w_ir_nxt;
    logic [OP_W-1:0]   w_op;
    logic [ADDR_W-1:0] w_cd;
    logic [DATA_W-1:0] w_alu_acc;
    logic              w_alu_zero;

    assign w_op = ir_op(r_ir);
    assign w_cd = ir_cd(r_ir);

    simplez_alu u_alu (
        .i_op        (w_op),
        .i_acc       (r_acc),
        .i_mem_din   (mem_din),
        .o_acc_nxt_c (w_alu_acc),
        .o_zero_c    (w_alu_zero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_acc   <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_acc   <= w_acc_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_acc_nxt   = r_acc;
        w_ir_nxt    = r_ir;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_ir_nxt    = mem_din;
                w_pc_nxt    = r_pc + ADDR_W'(1);
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                w_acc_nxt   = w_alu_acc;
                w_state_nxt = ST_FETCH;
                case (w_op)
                    OP_BR:   w_pc_nxt = w_cd;
                    OP_BZ:   if (w_alu_zero) w_pc_nxt = w_cd;
                    OP_HALT: w_state_nxt = ST_HALTED;
                    default: w_pc_nxt = r_pc;
                endcase
            end
            ST_HALTED: begin
                if (start) begin
                    w_pc_nxt    = RESET_PC;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Memory interface is decoded from registers only so it is stable at the memory's negedge sample.
    always_comb begin
        mem_addr = r_pc;
        mem_wr   = 1'b0;
        if (r_state == ST_EXEC) begin
            mem_addr = w_cd;
            mem_wr   = (w_op == OP_ST);
        end
    end

    assign mem_dout = r_acc;
    assign halt     = (r_state == ST_HALTED);
    assign acc      = r_acc;
    assign pc       = r_pc;

endmodule

// File: tb/tb_simplez_cpu.sv
// Self-checking bench: instruction-level Simplez model against the CPU with a negedge-sampled 512x12 memory.
module tb_simplez_cpu;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [11:0] mem_din;
    logic [8:0]  mem_addr;
    logic        mem_wr;
    logic [11:0] mem_dout;
    logic        halt;
    logic [11:0] acc;
    logic [8:0]  pc;

    int total;
    int bad;

    logic [11:0] tb_mem [512];
    logic [11:0] img    [512];
    logic        load_req;

    int ref_mem [512];
    int m_pc;
    int m_acc;
    bit m_halt;

    simplez_cpu dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .mem_din  (mem_din),
        .mem_addr (mem_addr),
        .mem_wr   (mem_wr),
        .mem_dout (mem_dout),
        .halt     (halt),
        .acc      (acc),
        .pc       (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program/data memory: samples address, strobe and data on the falling edge.
    always @(negedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 512; i++) tb_mem[i] <= img[i];
        end else if (mem_wr) begin
            tb_mem[mem_addr] <= mem_dout;
        end
        mem_din <= tb_mem[mem_addr];
    end

    task automatic chk_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0o exp=%0o (octal) at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 512; i++) img[i] = 12'o0;
    endtask

    // Hold reset, load the image into both memories, then release between clock edges.
    task automatic do_reset();
        rstn     = 1'b0;
        start    = 1'b0;
        load_req = 1'b1;
        @(negedge clk);
        #1;
        load_req = 1'b0;
        for (int i = 0; i < 512; i++) ref_mem[i] = int'(img[i]);
        m_pc   = 0;
        m_acc  = 0;
        m_halt = 1'b0;
        chk_eq("rst_pc", int'(pc), 0);
        chk_eq("rst_acc", int'(acc), 0);
        chk_eq("rst_wr", int'(mem_wr), 0);
        chk_eq("rst_halt", int'(halt), 0);
        chk_eq("rst_addr", int'(mem_addr), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One start pulse from IDLE or HALTED; the model restarts at PC 0 from HALTED.
    task automatic start_cpu();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (m_halt) m_pc = 0;
        m_halt = 1'b0;
        chk_eq("start_halt", int'(halt), 0);
        chk_eq("start_pc", int'(pc), m_pc);
        chk_eq("start_addr", int'(mem_addr), m_pc);
        chk_eq("start_acc", int'(acc), m_acc);
    endtask

    // Run one instruction (two clocks) on the DUT and one ISA step on the model.
    task automatic step_insn();
        int w, op, cd;
        chk_eq("fetch_addr", int'(mem_addr), m_pc);
        chk_eq("fetch_wr", int'(mem_wr), 0);
        @(posedge clk);
        #1;
        w    = ref_mem[m_pc];
        op   = w / 512;
        cd   = w % 512;
        m_pc = (m_pc + 1) % 512;
        chk_eq("exec_addr", int'(mem_addr), cd);
        chk_eq("exec_wr", int'(mem_wr), (op == 0) ? 1 : 0);
        chk_eq("exec_dout", int'(mem_dout), m_acc);
        chk_eq("exec_pc", int'(pc), m_pc);
        @(posedge clk);
        #1;
        case (op)
            0: ref_mem[cd] = m_acc;
            1: m_acc = ref_mem[cd];
            2: m_acc = (m_acc + ref_mem[cd]) % 4096;
            3: m_pc = cd;
            4: if (m_acc == 0) m_pc = cd;
            5: m_acc = 0;
            6: m_acc = (m_acc + 4095) % 4096;
            default: m_halt = 1'b1;
        endcase
        chk_eq("acc", int'(acc), m_acc);
        chk_eq("pc", int'(pc), m_pc);
        chk_eq("halt", int'(halt), m_halt ? 1 : 0);
    endtask

    task automatic chk_mem_image(input string tag);
        int diff;
        diff = 0;
        for (int i = 0; i < 512; i++) if (int'(tb_mem[i]) != ref_mem[i]) diff++;
        chk_eq(tag, diff, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        total    = 0;
        bad      = 0;
        rstn     = 1'b0;
        start    = 1'b0;
        load_req = 1'b0;

        // Asynchronous reset in the middle of an ST, then the CPU must idle until start.
        clear_img();
        img[0] = 12'o0100;
        do_reset();
        start_cpu();
        @(posedge clk);
        #1;
        chk_eq("st_wr_before_rst", int'(mem_wr), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk_eq("midrst_wr", int'(mem_wr), 0);
        chk_eq("midrst_halt", int'(halt), 0);
        chk_eq("midrst_pc", int'(pc), 0);
        chk_eq("midrst_acc", int'(acc), 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("idle_pc", int'(pc), 0);
        chk_eq("idle_addr", int'(mem_addr), 0);
        chk_eq("idle_wr", int'(mem_wr), 0);

        // Load / store / halt.
        clear_img();
        img[0] = 12'o1006; img[1] = 12'o0100; img[2] = 12'o7000; img[6] = 12'o0001;
        do_reset();
        start_cpu();
        step_insn();
        chk_eq("ldst_acc", int'(acc), 1);
        step_insn();
        chk_eq("ldst_halt_early", int'(halt), 0);
        step_insn();
        chk_eq("ldst_halt", int'(halt), 1);
        chk_eq("ldst_pc", int'(pc), 3);
        chk_eq("ldst_mem100", int'(tb_mem[9'o100]), 1);

        // ADD with carry out discarded.
        clear_img();
        img[0] = 12'o1006; img[1] = 12'o2005; img[2] = 12'o7000;
        img[5] = 12'o7777; img[6] = 12'o0002;
        do_reset();
        start_cpu();
        repeat (3) step_insn();
        chk_eq("add_ovf_acc", int'(acc), 1);

        // BZ taken after CLR, not taken after DEC from zero.
        clear_img();
        img[0] = 12'o5000; img[1] = 12'o4020;
        img[9'o20] = 12'o6000; img[9'o21] = 12'o4030; img[9'o22] = 12'o7000;
        do_reset();
        start_cpu();
        repeat (2) step_insn();
        chk_eq("bz_taken_pc", int'(pc), 9'o20);
        step_insn();
        chk_eq("dec_wrap_acc", int'(acc), 12'o7777);
        step_insn();
        chk_eq("bz_not_taken_pc", int'(pc), 9'o22);
        step_insn();

        // PC wraps from 511 to 0.
        clear_img();
        img[0] = 12'o3777; img[9'o777] = 12'o5000;
        do_reset();
        start_cpu();
        repeat (2) step_insn();
        chk_eq("wrap_fetch_addr", int'(mem_addr), 0);

        // Self-modifying: ST overwrites the next instruction with HALT.
        clear_img();
        img[0] = 12'o1005; img[1] = 12'o0002; img[5] = 12'o7000;
        do_reset();
        start_cpu();
        repeat (3) step_insn();
        chk_eq("selfmod_halt", int'(halt), 1);
        chk_eq("selfmod_pc", int'(pc), 3);

        // Restart from HALTED keeps ACC.
        clear_img();
        img[0] = 12'o1004; img[1] = 12'o7000; img[4] = 12'o0007;
        do_reset();
        start_cpu();
        repeat (2) step_insn();
        start_cpu();
        chk_eq("restart_acc", int'(acc), 7);
        chk_eq("restart_pc", int'(pc), 0);
        step_insn();

        // Random memory images, each run until HALT (with one restart) or an instruction budget.
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < 512; i++) img[i] = 12'($urandom_range(0, 4095));
            do_reset();
            for (int run = 0; run < 2; run++) begin
                int n;
                start_cpu();
                n = 0;
                while (!m_halt && n < 120) begin
                    step_insn();
                    n++;
                end
                if (!m_halt) break;
            end
            chk_mem_image("rand_mem_image");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
